// File: rtl/axis_stream_pkg.sv
// Shared sizing helpers for the buffered AXI4-Stream master.
// The optional packet counter is selected with the macro AXIS_PKT_COUNTER_EN.
package axis_stream_pkg;

   // Pointer width for a power-of-two FIFO; at least one bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 32'd1) ? $clog2(depth) : 32'd1;
   endfunction

   // Occupancy counter width: must be able to represent DEPTH itself.
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth + 32'd1);
   endfunction

   // Stored entry width: one tlast bit on top of the data word.
   function automatic int unsigned entry_width(input int unsigned data_width);
      return data_width + 32'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a
// first-word-fall-through read port (head visible without a read strobe).
module sync_fifo
   import axis_stream_pkg::*;
#(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic                          rd_en,
   output logic [WIDTH-1:0]              rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned LVL_W = level_width(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic [LVL_W-1:0] level_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             wr_ok_s;
   logic             rd_ok_s;

   assign wr_ok_s = wr_en && !full_r;
   assign rd_ok_s = rd_en && !empty_r;

   // Next occupancy: simultaneous write and read leave it unchanged.
   always_comb begin
      level_nxt_s = level_r;
      case ({wr_ok_s, rd_ok_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Pointers, occupancy and flags; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= LVL_ZERO;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r <= level_nxt_s;
         full_r  <= (level_nxt_s == LVL_FULL);
         empty_r <= (level_nxt_s == LVL_ZERO);
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign full    = full_r;
   assign empty   = empty_r;
   assign level   = level_r;

endmodule

// File: rtl/axis_stream_buffer.sv
// Buffered AXI4-Stream master: FIFO plus registered output stage with a
// bypass path for one beat per clock. TLAST comes from pi_tlast, or from an
// internal beat counter when AXIS_PKT_COUNTER_EN is defined.
module axis_stream_buffer
   import axis_stream_pkg::*;
#(
   parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned DEPTH                = 8,
   parameter int unsigned PKT_LEN_WIDTH        = 16
) (
   input  logic                              M_AXIS_ACLK,
   input  logic                              M_AXIS_ARESET,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   pi_r_data,
   input  logic                              pi_tlast,
   input  logic                              pi_data_valid,
   output logic                              po_read_data,
   input  logic [PKT_LEN_WIDTH-1:0]          pi_pkt_len,
   output logic [level_width(DEPTH)-1:0]     po_level,
   output logic                              po_pkt_done,
   output logic                              M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY
);

   localparam int unsigned EW = entry_width(C_M_AXIS_TDATA_WIDTH);

   typedef struct packed {
      logic                            tlast;
      logic [C_M_AXIS_TDATA_WIDTH-1:0] data;
   } fifo_entry_t;

   fifo_entry_t                      in_entry_s;
   fifo_entry_t                      head_entry_s;
   logic [EW-1:0]                    head_raw_s;
   logic                             fifo_full_s;
   logic                             fifo_empty_s;
   logic                             push_s;
   logic                             accept_s;
   logic                             out_free_s;
   logic                             bypass_s;
   logic                             pop_s;
   logic                             fifo_wr_s;
   logic                             tlast_in_s;
   logic                             tvalid_r;
   logic [C_M_AXIS_TDATA_WIDTH-1:0]  tdata_r;
   logic                             tlast_r;

   // Handshake: full is registered, so po_read_data has no path from pi_data_valid.
   assign po_read_data = !fifo_full_s;
   assign push_s       = pi_data_valid && !fifo_full_s;
   assign accept_s     = tvalid_r && M_AXIS_TREADY;
   assign out_free_s   = !tvalid_r || accept_s;
   // The FIFO head has priority over the incoming word so order is kept.
   assign pop_s        = out_free_s && !fifo_empty_s;
   assign bypass_s     = push_s && fifo_empty_s && out_free_s;
   assign fifo_wr_s    = push_s && !bypass_s;

`ifdef AXIS_PKT_COUNTER_EN
   localparam logic [PKT_LEN_WIDTH-1:0] LEN_ZERO = PKT_LEN_WIDTH'(0);
   localparam logic [PKT_LEN_WIDTH-1:0] LEN_ONE  = PKT_LEN_WIDTH'(1);

   logic [PKT_LEN_WIDTH-1:0] beat_cnt_r;
   logic [PKT_LEN_WIDTH-1:0] pkt_len_r;
   logic [PKT_LEN_WIDTH-1:0] eff_len_s;
   logic                     unused_tlast_s;

   assign unused_tlast_s = pi_tlast;

   // Packet length in force: sampled live on the first beat, zero means one.
   always_comb begin
      eff_len_s = pkt_len_r;
      if (beat_cnt_r == LEN_ZERO) begin
         eff_len_s = (pi_pkt_len == LEN_ZERO) ? LEN_ONE : pi_pkt_len;
      end else begin
         eff_len_s = pkt_len_r;
      end
   end

   assign tlast_in_s = (beat_cnt_r == (eff_len_s - LEN_ONE));

   // Beat counter advances per pushed word and restarts after the last beat.
   always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
      if (M_AXIS_ARESET) begin
         beat_cnt_r <= LEN_ZERO;
         pkt_len_r  <= LEN_ONE;
      end else if (push_s) begin
         if (beat_cnt_r == LEN_ZERO) begin
            pkt_len_r <= eff_len_s;
         end
         beat_cnt_r <= tlast_in_s ? LEN_ZERO : (beat_cnt_r + LEN_ONE);
      end
   end
`else
   logic unused_pkt_len_s;

   assign unused_pkt_len_s = ^pi_pkt_len;
   assign tlast_in_s       = pi_tlast;
`endif

   assign in_entry_s   = '{tlast: tlast_in_s, data: pi_r_data};
   assign head_entry_s = fifo_entry_t'(head_raw_s);

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (M_AXIS_ACLK),
      .rst     (M_AXIS_ARESET),
      .wr_en   (fifo_wr_s),
      .wr_data (in_entry_s),
      .rd_en   (pop_s),
      .rd_data (head_raw_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .level   (po_level)
   );

   // Output stage: refill from FIFO head, else bypass, else drop TVALID after a beat.
   always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
      if (M_AXIS_ARESET) begin
         tvalid_r <= 1'b0;
         tdata_r  <= {C_M_AXIS_TDATA_WIDTH{1'b0}};
         tlast_r  <= 1'b0;
      end else if (pop_s) begin
         tvalid_r <= 1'b1;
         tdata_r  <= head_entry_s.data;
         tlast_r  <= head_entry_s.tlast;
      end else if (bypass_s) begin
         tvalid_r <= 1'b1;
         tdata_r  <= in_entry_s.data;
         tlast_r  <= in_entry_s.tlast;
      end else if (accept_s) begin
         tvalid_r <= 1'b0;
      end
   end

   assign M_AXIS_TVALID = tvalid_r;
   assign M_AXIS_TDATA  = tdata_r;
   assign M_AXIS_TLAST  = tlast_r;
   assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};
   assign po_pkt_done   = tvalid_r && M_AXIS_TREADY && tlast_r;

endmodule
